// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: issue/result bundle for the iterative multiplier.
//   x, y       - operands, sampled only when start is accepted
//   is_signed  - 1 = two's-complement operands, 0 = unsigned
//   start      - request, honoured only when the unit is idle or done
//   z          - 2*WIDTH-bit product, holds until the next completion
//   busy       - high while an operation is in flight
//   done       - one-cycle pulse, z is valid in that cycle
// Handshake: start is a request qualified by !busy; a request seen while
// busy is dropped, not queued. done is a single-cycle pulse with no back
// pressure; the consumer must capture z then or read the held value later.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               is_signed;
  logic               start;
  logic [2*WIDTH-1:0] z;
  logic               busy;
  logic               done;

  modport master (
    output x, y, is_signed, start,
    input  z, busy, done
  );

  modport slave (
    input  x, y, is_signed, start,
    output z, busy, done
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   mif        - seq_multiplier_if slave (x, y, is_signed, start, z, busy, done)
//   dbg_state  - current FSM state (0 IDLE, 1 CALC, 2 DONE)
// A start accepted in IDLE or DONE is followed by exactly WIDTH CALC cycles
// and then a DONE cycle carrying the product.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_multiplier_if.slave      mif,
  output logic [1:0]           dbg_state
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;   // multiplicand, extended and shifted left each step
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
  logic             sgn_q, sgn_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_next;

  // Partial product for the current multiplier bit. In signed mode the MSB of
  // the multiplier carries weight -2^(WIDTH-1), so the last step subtracts.
  always_comb begin
    pp       = mplier_q[0] ? mcand_q : '0;
    acc_next = (cnt_q == '0 && sgn_q) ? (acc_q - pp) : (acc_q + pp);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    z_d      = z_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (mif.start) begin
          mcand_d  = {{WIDTH{mif.is_signed & mif.x[WIDTH-1]}}, mif.x};
          mplier_d = mif.y;
          sgn_d    = mif.is_signed;
          cnt_d    = CNT_W'(WIDTH - 1);
          acc_d    = '0;
          state_d  = CALC;
          busy_d   = 1'b1;
        end else begin
          state_d  = IDLE;
          busy_d   = 1'b0;
        end
      end
      CALC: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          z_d     = acc_next;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      z_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mif.z     = z_q;
  assign mif.busy  = busy_q;
  assign mif.done  = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(W)) mif ();
  logic [1:0] dbg_state;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mif       (mif),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [PW-1:0] last_exp = '0;

  // Reference: exact integer product, operands interpreted by mode.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic s);
    longint ia, ib, p;
    ia = s ? longint'($signed(a)) : longint'({1'b0, a});
    ib = s ? longint'($signed(b)) : longint'({1'b0, b});
    p  = ia * ib;
    return p[PW-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also guards busy/done exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (mif.busy && mif.done) begin
        n_checks++;
        n_fail++;
        $display("FAIL busy_done_overlap: busy=%b done=%b", mif.busy, mif.done);
      end
      if (mif.done) begin
        done_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: z=%0h with empty queue", mif.z);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          if (mif.z !== e) begin
            n_fail++;
            $display("FAIL product: z=%0h expected %0h", mif.z, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    mif.x = a; mif.y = b; mif.is_signed = s; mif.start = 1'b1;
    last_exp = model(a, b, s);
    exp_q.push_back(last_exp);
    @(negedge clk);
    mif.start = 1'b0;
    mif.x = W'($urandom); mif.y = W'($urandom); mif.is_signed = 1'($urandom);
  endtask

  // Counts busy cycles until done; returns at the negedge where done is high.
  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (mif.done) begin seen = 1; break; end
      if (mif.busy) n++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_latency"}, n, W);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    mif.x = '0; mif.y = '0; mif.is_signed = 1'b0; mif.start = 1'b0;
    rst = 1'b1;
    idle_cycles(3);
    check("reset_z", mif.z, 0);
    check("reset_busy", mif.busy, 0);
    check("reset_done", mif.done, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    idle_cycles(1);

    // -3 * 5 signed
    start_op(8'hFD, 8'h05, 1'b1);
    check("busy_after_start", mif.busy, 1);
    wait_done("neg3x5");
    check("neg3x5_z", mif.z, 16'hFFF1);
    idle_cycles(3);
    check("z_hold", mif.z, 16'hFFF1);
    check("done_low_idle", mif.done, 0);

    // table of directed cases
    start_op(8'hFF, 8'hFF, 1'b0); wait_done("ff_u"); idle_cycles(1);
    start_op(8'hFF, 8'hFF, 1'b1); wait_done("ff_s"); idle_cycles(1);
    start_op(8'h80, 8'h80, 1'b1); wait_done("min_min"); idle_cycles(1);
    start_op(8'h80, 8'h01, 1'b1); wait_done("min_one"); idle_cycles(1);
    start_op(8'h00, 8'h7F, 1'b1); wait_done("zero"); idle_cycles(1);
    check("zero_z", mif.z, 16'h0000);

    // start during CALC is ignored
    d0 = done_cnt;
    start_op(8'h03, 8'h04, 1'b0);
    idle_cycles(2);
    mif.x = 8'h09; mif.y = 8'h09; mif.is_signed = 1'b1; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0; mif.is_signed = 1'b0;
    for (int i = 0; i < 20 && !mif.done; i++) @(negedge clk);
    check("ignored_start_z", mif.z, 16'h000C);
    idle_cycles(W + 3);
    check("ignored_start_one_done", done_cnt - d0, 1);

    // back-to-back: new start in the DONE cycle
    start_op(8'h05, 8'h06, 1'b0);
    wait_done("b2b_first");
    start_op(8'h02, 8'h03, 1'b0);
    check("b2b_busy", mif.busy, 1);
    wait_done("b2b_second");
    check("b2b_z", mif.z, 16'h0006);
    idle_cycles(1);

    // reset mid-operation aborts
    d0 = done_cnt;
    start_op(8'h07, 8'h07, 1'b0);
    idle_cycles(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("abort_busy", mif.busy, 0);
    check("abort_done", mif.done, 0);
    check("abort_z", mif.z, 0);
    idle_cycles(W + 2);
    check("abort_no_done", done_cnt - d0, 0);
    start_op(8'h07, 8'h07, 1'b0); wait_done("after_abort");
    check("after_abort_z", mif.z, 16'h0031);

    // randomized operations with random gaps (0 = back-to-back)
    for (int i = 0; i < 60; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done("rand");
      if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(4);
    check("final_z_hold", mif.z, last_exp);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
